// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares one memory command/read port between I-cache refills and
//           D-cache refills/write-throughs, one transaction at a time.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  output logic                i_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                d_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [4:0]          mem_len,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                busy,
  output logic [1:0]          grant
);

  localparam int CNT_W    = $clog2(BURST_LEN);
  localparam int LINE_OFF = CNT_W + 2;
  localparam int STRB_W   = DATA_W / 8;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_addr = 2'd1;
  localparam logic [1:0] c_st_data = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [ADDR_W-1:0] c_line_mask = {ADDR_W{1'b1}} << LINE_OFF;
  localparam logic [ADDR_W-1:0] c_word_mask = {ADDR_W{1'b1}} << 2;
  localparam logic [CNT_W-1:0]  c_last_beat = CNT_W'(BURST_LEN - 1);
  localparam logic [4:0]        c_burst_len = 5'(BURST_LEN);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_owner_d;
  logic              r_last_d;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              w_take;
  logic              w_grant_d;
  logic              w_beat;

  assign w_take    = (r_state == c_st_idle) && (i_req || d_req);
  // D wins a tie unless it also won the previous grant.
  assign w_grant_d = d_req && (!i_req || !r_last_d);
  assign w_beat    = (r_state == c_st_data) && mem_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (i_req || d_req) w_next_state = c_st_addr;
      c_st_addr: if (mem_ready) w_next_state = r_we ? c_st_done : c_st_data;
      c_st_data: if (mem_rvalid && (r_beat_cnt == c_last_beat)) w_next_state = c_st_done;
      default:   w_next_state = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_d  <= 1'b0;
      r_last_d   <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_take) begin
        r_owner_d  <= w_grant_d;
        r_last_d   <= w_grant_d;
        r_addr     <= w_grant_d ? d_addr : i_addr;
        r_we       <= w_grant_d && d_we;
        r_wdata    <= w_grant_d ? d_wdata : '0;
        r_wstrb    <= w_grant_d ? d_wstrb : '0;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    i_rdata   = '0;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_rdata   = '0;
    d_rvalid  = 1'b0;
    d_done    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_len   = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    busy      = (r_state != c_st_idle);
    grant     = busy ? (r_owner_d ? 2'b10 : 2'b01) : 2'b00;
    case (r_state)
      c_st_addr: begin
        mem_req = 1'b1;
        if (r_we) begin
          mem_we    = 1'b1;
          mem_addr  = r_addr & c_word_mask;
          mem_len   = 5'd1;
          mem_wdata = r_wdata;
          mem_wstrb = r_wstrb;
        end else begin
          mem_addr = r_addr & c_line_mask;
          mem_len  = c_burst_len;
        end
      end
      c_st_data: begin
        if (mem_rvalid) begin
          if (r_owner_d) begin
            d_rdata  = mem_rdata;
            d_rvalid = 1'b1;
          end else begin
            i_rdata  = mem_rdata;
            i_rvalid = 1'b1;
          end
        end
      end
      c_st_done: begin
        d_done = r_owner_d;
        i_done = !r_owner_d;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Directed scoreboard bench for mem_bus_arbiter.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_rvalid, i_done;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_rvalid, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [SW-1:0] d_wstrb;
  logic          mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [AW-1:0] mem_addr;
  logic [4:0]    mem_len;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;
  logic [1:0]    grant;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;  // 0 command, 1 read beat, 2 done
    bit            d;
    bit            we;
    logic [AW-1:0] addr;
    logic [4:0]    len;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            hold;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  req_run  = 0;
  int  d_beats  = 0;

  function automatic void push_cmd(bit d, bit we, logic [AW-1:0] addr, logic [4:0] len,
                                   logic [DW-1:0] data, logic [SW-1:0] strb, int hold);
    ev_t e;
    e.kind = 0; e.d = d; e.we = we; e.addr = addr; e.len = len;
    e.data = data; e.strb = strb; e.hold = hold;
    exp_q.push_back(e);
  endfunction

  function automatic void push_ev(int kind, bit d, logic [DW-1:0] data);
    ev_t e;
    e.kind = kind; e.d = d; e.we = 1'b0; e.addr = '0; e.len = '0;
    e.data = data; e.strb = '0; e.hold = 0;
    exp_q.push_back(e);
  endfunction

  task automatic check_val(input string name, input logic [145:0] act, input logic [145:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [1:0] who, input logic we,
                         input logic [AW-1:0] addr, input logic [4:0] len,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb, input int hold);
    ev_t   e;
    bit    bad;
    string kn;
    kn = (kind == 0) ? "cmd" : (kind == 1) ? "beat" : "done";
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s @%0d: got who=%b addr=%h data=%h, expected no event",
               kn, cyc, who, addr, data);
      return;
    end
    e   = exp_q.pop_front();
    bad = (e.kind != kind) || (who !== (e.d ? 2'b10 : 2'b01));
    if (kind == 0)
      bad = bad || (we !== e.we) || (addr !== e.addr) || (len !== e.len) || (hold != e.hold) ||
            (e.we && ((data !== e.data) || (strb !== e.strb)));
    if (kind == 1)
      bad = bad || (data !== e.data);
    if (bad) begin
      n_errors++;
      $display("FAIL %s @%0d: got kind=%0d who=%b we=%b addr=%h len=%0d data=%h strb=%b hold=%0d, expected kind=%0d who=%b we=%b addr=%h len=%0d data=%h strb=%b hold=%0d",
               kn, cyc, kind, who, we, addr, len, data, strb, hold,
               e.kind, (e.d ? 2'b10 : 2'b01), e.we, e.addr, e.len, e.data, e.strb, e.hold);
    end
  endtask

  // Monitor: every DUT-presented event is matched against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      req_run = 0;
    end else begin
      req_run = mem_req ? req_run + 1 : 0;
      if (mem_req && mem_ready) begin
        observe(0, grant, mem_we, mem_addr, mem_len, mem_wdata, mem_wstrb, req_run);
        req_run = 0;
      end
      if (i_rvalid) observe(1, 2'b01, 1'b0, '0, '0, i_rdata, '0, 0);
      if (d_rvalid) begin
        d_beats++;
        observe(1, 2'b10, 1'b0, '0, '0, d_rdata, '0, 0);
      end
      if (i_done) observe(2, 2'b01, 1'b0, '0, '0, '0, '0, 0);
      if (d_done) observe(2, 2'b10, 1'b0, '0, '0, '0, '0, 0);
    end
  end

  task automatic accept_cmd(input int delay, input bit junk, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    while (!mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!mem_req) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_timeout: mem_req=%0b after %0d cycles, expected 1", mem_req, n);
      return;
    end
    mem_rvalid = junk;
    mem_rdata  = junk ? 32'hBAD0_BAD0 : '0;
    repeat (delay) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    acc_cyc   = cyc;
    @(posedge clk); #1;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic send_beats(input logic [15:0] pat, input int n, input bit d, input logic [DW-1:0] base);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      mem_rvalid = pat[i];
      mem_rdata  = pat[i] ? base + DW'(k) : '0;
      if (pat[i]) begin
        push_ev(1, d, base + DW'(k));
        k++;
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic wait_done(input bit d, output int seen);
    seen = -1;
    for (int n = 0; n < 40; n++) begin
      if (d ? d_done : i_done) begin
        seen = cyc;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL done_timeout: %s_done stayed 0 for 40 cycles, expected 1", d ? "d" : "i");
  endtask

  task automatic refill(input bit d, input logic [AW-1:0] line, input logic [15:0] pat, input int n,
                        input logic [DW-1:0] base, input int delay, input bit junk, output int dn);
    int acc;
    push_cmd(d, 1'b0, line, 5'd4, '0, '0, delay + 1);
    accept_cmd(delay, junk, acc);
    send_beats(pat, n, d, base);
    push_ev(2, d, '0);
    wait_done(d, dn);
  endtask

  function automatic logic [145:0] all_outs();
    return {i_rdata, i_rvalid, i_done, d_rdata, d_rvalid, d_done, mem_req, mem_we,
            mem_addr, mem_len, mem_wdata, mem_wstrb, busy, grant};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, acc, dn, beats0;
    rst = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 0; mem_rdata = '0; mem_rvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both requesting from reset: D, I, D, I.
    i_addr = 32'h0000_8010; d_addr = 32'h0000_9024; d_we = 1'b0;
    i_req = 1; d_req = 1;
    for (int t = 0; t < 4; t++) begin
      bit d;
      d = (t % 2 == 0);
      refill(d, d ? 32'h0000_9020 : 32'h0000_8010, 16'h000F, 4,
             d ? 32'hD000_0000 + 32'(t * 16) : 32'hC000_0000 + 32'(t * 16), 0, 1'b0, dn);
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    @(posedge clk); #1;

    // Lone I refill with minimum latency.
    i_addr = 32'h0000_104C; i_req = 1; t0 = cyc;
    push_cmd(1'b0, 1'b0, 32'h0000_1040, 5'd4, '0, '0, 1);
    accept_cmd(0, 1'b0, acc);
    check_val("i_accept_cycle", 146'(acc - t0), 146'd1);
    send_beats(16'h000F, 4, 1'b0, 32'h0000_00A0);
    push_ev(2, 1'b0, '0);
    wait_done(1'b0, dn);
    check_val("i_done_cycle", 146'(dn - t0), 146'd6);
    @(posedge clk); #1;
    i_req = 0;
    @(posedge clk); #1;

    // D write-through, command accepted on its third cycle.
    d_addr = 32'h0000_2002; d_we = 1; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; d_req = 1;
    push_cmd(1'b1, 1'b1, 32'h0000_2000, 5'd1, 32'hDEAD_BEEF, 4'b0011, 3);
    accept_cmd(2, 1'b0, acc);
    push_ev(2, 1'b1, '0);
    wait_done(1'b1, dn);
    check_val("d_write_done_cycle", 146'(dn - acc), 146'd1);
    @(posedge clk); #1;
    d_req = 0; d_we = 0;
    @(posedge clk); #1;

    // D refill with gaps, stray rvalid while in ADDR.
    d_addr = 32'h0000_3014; d_req = 1; beats0 = d_beats;
    refill(1'b1, 32'h0000_3010, 16'h0059, 7, 32'h0000_3300, 1, 1'b1, dn);
    check_val("gap_beat_count", 146'(d_beats - beats0), 146'd4);
    @(posedge clk); #1;
    d_req = 0;
    @(posedge clk); #1;

    // Reset after two beats of an I refill.
    i_addr = 32'h0000_4008; i_req = 1;
    push_cmd(1'b0, 1'b0, 32'h0000_4000, 5'd4, '0, '0, 1);
    accept_cmd(0, 1'b0, acc);
    send_beats(16'h0003, 2, 1'b0, 32'h0000_4400);
    rst = 1; i_req = 0;
    #1;
    check_val("reset_abort_now", all_outs(), '0);
    @(posedge clk); #1;
    check_val("reset_abort_edge", all_outs(), '0);
    rst = 0;
    @(posedge clk); #1;
    check_val("reset_release_idle", 146'(busy), 146'd0);

    // Tie after reset goes to D, then I.
    i_addr = 32'h0000_6004; d_addr = 32'h0000_5000; d_we = 0;
    i_req = 1; d_req = 1;
    refill(1'b1, 32'h0000_5000, 16'h000F, 4, 32'h0000_5500, 0, 1'b0, dn);
    @(posedge clk); #1;
    d_req = 0;
    refill(1'b0, 32'h0000_6000, 16'h000F, 4, 32'h0000_6600, 0, 1'b0, dn);
    @(posedge clk); #1;
    i_req = 0;
    @(posedge clk); #1;

    // D drops its request while the command is pending.
    d_addr = 32'h0000_7004; d_we = 1; d_wdata = 32'h1234_5678; d_wstrb = 4'b1111; d_req = 1;
    push_cmd(1'b1, 1'b1, 32'h0000_7004, 5'd1, 32'h1234_5678, 4'b1111, 2);
    @(posedge clk); #1;
    d_req = 0;
    accept_cmd(1, 1'b0, acc);
    push_ev(2, 1'b1, '0);
    wait_done(1'b1, dn);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_val("drop_no_second_txn", 146'({busy, mem_req}), 146'd0);

    check_val("expected_queue_empty", 146'(exp_q.size()), 146'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
